fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch / branch-resolve sequencer. All outputs are registered and
// are computed from the transition being taken on each clock edge.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        br_req,
   input  logic [3:0]  br_cond,
   input  logic        br_rel,
   input  logic [15:0] br_target,
   input  logic [15:0] pc,
   input  logic [15:0] psr,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        mem_rd_req,
   output logic [15:0] mem_addr,
   output logic [15:0] pc_next,
   output logic        pc_en,
   output logic [15:0] instr_next,
   output logic        instr_en,
   output logic        br_taken,
   output logic        busy
);

   // PEND is the INIT-pending state held while reset is asserted; the INIT
   // cycle (pc_en with RESET_PC) is the first registered cycle after release.
   typedef enum logic [2:0] {PEND, INIT, IDLE, FETCH, WB, BRANCH} state_t;

   state_t      state, state_nx;
   logic        mem_rd_req_nx, pc_en_nx, instr_en_nx, br_taken_nx;
   logic [15:0] mem_addr_nx, pc_next_nx, instr_next_nx;
   logic        cond_ok;
   logic        flag_c, flag_l, flag_f, flag_z, flag_n;
   logic        unused_psr;

   assign flag_c     = psr[0];
   assign flag_l     = psr[2];
   assign flag_f     = psr[5];
   assign flag_z     = psr[6];
   assign flag_n     = psr[7];
   assign unused_psr = ^{psr[15:8], psr[4:3], psr[1]};

   always_comb begin
      cond_ok = 1'b0;
      case (br_cond)
         4'b0000: cond_ok = flag_z;
         4'b0001: cond_ok = !flag_z;
         4'b0010: cond_ok = flag_c;
         4'b0011: cond_ok = !flag_c;
         4'b0100: cond_ok = flag_l;
         4'b0101: cond_ok = !flag_l;
         4'b0110: cond_ok = flag_n;
         4'b0111: cond_ok = !flag_n;
         4'b1000: cond_ok = flag_f;
         4'b1001: cond_ok = !flag_f;
         4'b1010: cond_ok = !flag_l && !flag_z;
         4'b1011: cond_ok = flag_l || flag_z;
         4'b1100: cond_ok = !flag_n && !flag_z;
         4'b1101: cond_ok = flag_n || flag_z;
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_nx      = state;
      mem_rd_req_nx = mem_rd_req;
      mem_addr_nx   = mem_addr;
      pc_next_nx    = pc_next;
      instr_next_nx = instr_next;
      pc_en_nx      = 1'b0;
      instr_en_nx   = 1'b0;
      br_taken_nx   = 1'b0;
      case (state)
         PEND: begin
            state_nx   = INIT;
            pc_en_nx   = 1'b1;
            pc_next_nx = RESET_PC;
         end
         INIT: state_nx = IDLE;
         IDLE: begin
            // Branch wins; a coincident start is dropped.
            if (br_req) begin
               state_nx    = BRANCH;
               pc_en_nx    = 1'b1;
               br_taken_nx = cond_ok;
               if (!cond_ok)
                  pc_next_nx = pc + 16'd1;
               else if (br_rel)
                  pc_next_nx = pc + br_target;
               else
                  pc_next_nx = br_target;
            end else if (start) begin
               state_nx      = FETCH;
               mem_rd_req_nx = 1'b1;
               mem_addr_nx   = pc;
            end
         end
         FETCH: begin
            if (mem_ack) begin
               state_nx      = WB;
               mem_rd_req_nx = 1'b0;
               instr_next_nx = mem_rdata;
               instr_en_nx   = 1'b1;
               pc_en_nx      = 1'b1;
               pc_next_nx    = pc + 16'd1;
            end
         end
         WB:      state_nx = IDLE;
         BRANCH:  state_nx = IDLE;
         default: state_nx = PEND;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= PEND;
         mem_rd_req <= 1'b0;
         mem_addr   <= 16'h0000;
         pc_next    <= 16'h0000;
         pc_en      <= 1'b0;
         instr_next <= 16'h0000;
         instr_en   <= 1'b0;
         br_taken   <= 1'b0;
         busy       <= 1'b1;
      end else begin
         state      <= state_nx;
         mem_rd_req <= mem_rd_req_nx;
         mem_addr   <= mem_addr_nx;
         pc_next    <= pc_next_nx;
         pc_en      <= pc_en_nx;
         instr_next <= instr_next_nx;
         instr_en   <= instr_en_nx;
         br_taken   <= br_taken_nx;
         busy       <= (state_nx != IDLE);
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed literal checks plus randomized traffic compared every cycle
// against a transaction-level model of the fetch unit.
module tb_fetch_unit;
   localparam logic [15:0] RPC = 16'h0100;

   logic        clk = 1'b0, reset_n = 1'b1;
   logic        start = 1'b0, br_req = 1'b0, br_rel = 1'b0, mem_ack = 1'b0;
   logic [3:0]  br_cond = 4'h0;
   logic [15:0] br_target = 16'h0, pc = 16'h0, psr = 16'h0, mem_rdata = 16'h0;
   logic        mem_rd_req, pc_en, instr_en, br_taken, busy;
   logic [15:0] mem_addr, pc_next, instr_next;

   int checks = 0, errors = 0;
   bit chk_on = 1'b0;

   fetch_unit #(.RESET_PC(RPC)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .br_req(br_req),
      .br_cond(br_cond), .br_rel(br_rel), .br_target(br_target), .pc(pc),
      .psr(psr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .pc_next(pc_next),
      .pc_en(pc_en), .instr_next(instr_next), .instr_en(instr_en),
      .br_taken(br_taken), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit cond_true(input logic [3:0] cond, input logic [15:0] p);
      bit c, l, f, z, n;
      bit tbl [16];
      c = p[0]; l = p[2]; f = p[5]; z = p[6]; n = p[7];
      tbl = '{z, !z, c, !c, l, !l, n, !n, f, !f,
              !l && !z, l || z, !n && !z, n || z, 1'b1, 1'b0};
      return tbl[cond];
   endfunction

   // Model: what the unit is doing now, and the outputs it must show.
   localparam int M_RESET = 0, M_LOAD = 1, M_READY = 2, M_READ = 3, M_DONE = 4;
   int          m = M_RESET;
   bit          e_req = 0, e_pcen = 0, e_inen = 0, e_bt = 0, e_busy = 1;
   logic [15:0] e_addr = 0, e_pcn = 0, e_in = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m = M_RESET;
         e_req = 0; e_pcen = 0; e_inen = 0; e_bt = 0; e_busy = 1;
         e_addr = 0; e_pcn = 0; e_in = 0;
      end else begin
         e_pcen = 0; e_inen = 0; e_bt = 0;
         if (m == M_RESET) begin
            e_pcen = 1; e_pcn = RPC; m = M_LOAD;
         end else if (m == M_READY) begin
            if (br_req) begin
               e_pcen = 1;
               e_bt   = cond_true(br_cond, psr);
               e_pcn  = !e_bt ? 16'(pc + 1) : (br_rel ? 16'(pc + br_target) : br_target);
               m = M_DONE;
            end else if (start) begin
               e_req = 1; e_addr = pc; m = M_READ;
            end
         end else if (m == M_READ) begin
            if (mem_ack) begin
               e_req = 0; e_in = mem_rdata; e_inen = 1;
               e_pcen = 1; e_pcn = 16'(pc + 1); m = M_DONE;
            end
         end else begin
            m = M_READY;  // LOAD and DONE last one cycle each
         end
         e_busy = (m != M_READY);
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("busy", 16'(busy), 16'(e_busy));
         chk("mem_rd_req", 16'(mem_rd_req), 16'(e_req));
         if (e_req) chk("mem_addr", mem_addr, e_addr);
         chk("pc_en", 16'(pc_en), 16'(e_pcen));
         if (e_pcen) chk("pc_next", pc_next, e_pcn);
         chk("instr_en", 16'(instr_en), 16'(e_inen));
         if (e_inen) chk("instr_next", instr_next, e_in);
         chk("br_taken", 16'(br_taken), 16'(e_bt));
         chk("en_excl", 16'(instr_en & br_taken), 16'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 reset_n = 1'b0;
      chk_on = 1'b1;
      #1;
      chk("rst_req", 16'(mem_rd_req), 16'h0);
      chk("rst_busy", 16'(busy), 16'h1);
      chk("rst_pcn", pc_next, 16'h0);
      chk("rst_addr", mem_addr, 16'h0);
      chk("rst_instr", instr_next, 16'h0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();
      chk("init_pcen", 16'(pc_en), 16'h1);
      chk("init_pcn", pc_next, 16'h0100);
      chk("init_busy", 16'(busy), 16'h1);
      tick();
      chk("idle_busy", 16'(busy), 16'h0);
      chk("idle_pcen", 16'(pc_en), 16'h0);

      // fetch with 3 cycles of request
      pc = 16'h0010; start = 1'b1;
      tick(); start = 1'b0;
      chk("f_req1", 16'(mem_rd_req), 16'h1);
      chk("f_addr1", mem_addr, 16'h0010);
      tick();
      chk("f_addr2", mem_addr, 16'h0010);
      tick();
      chk("f_addr3", mem_addr, 16'h0010);
      chk("f_req3", 16'(mem_rd_req), 16'h1);
      mem_ack = 1'b1; mem_rdata = 16'hA5C3;
      tick(); mem_ack = 1'b0;
      chk("wb_inen", 16'(instr_en), 16'h1);
      chk("wb_instr", instr_next, 16'hA5C3);
      chk("wb_pcen", 16'(pc_en), 16'h1);
      chk("wb_pcn", pc_next, 16'h0011);
      chk("wb_req", 16'(mem_rd_req), 16'h0);
      tick();
      chk("wb_idle", 16'(busy), 16'h0);

      // PC wrap with zero-wait ack
      pc = 16'hFFFF; start = 1'b1;
      tick(); start = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1234;
      tick(); mem_ack = 1'b0;
      chk("wrap_pcn", pc_next, 16'h0000);
      chk("wrap_inen", 16'(instr_en), 16'h1);
      tick();

      // taken relative branch on EQ
      psr = 16'h0040; pc = 16'h0020; br_req = 1'b1; br_cond = 4'b0000;
      br_rel = 1'b1; br_target = 16'hFFFC;
      tick(); br_req = 1'b0;
      chk("beq_bt", 16'(br_taken), 16'h1);
      chk("beq_pcn", pc_next, 16'h001C);
      chk("beq_inen", 16'(instr_en), 16'h0);
      tick();
      chk("beq_idle", 16'(busy), 16'h0);

      // LT with Z=1: not taken
      br_req = 1'b1; br_cond = 4'b1100;
      tick(); br_req = 1'b0;
      chk("blt_bt", 16'(br_taken), 16'h0);
      chk("blt_pcn", pc_next, 16'h0021);
      chk("blt_pcen", 16'(pc_en), 16'h1);
      tick();

      // never
      br_req = 1'b1; br_cond = 4'b1111; psr = 16'h00FF;
      tick(); br_req = 1'b0;
      chk("bnv_bt", 16'(br_taken), 16'h0);
      tick();

      // start + br_req together: branch only
      start = 1'b1; br_req = 1'b1; br_cond = 4'b1110; br_rel = 1'b0; br_target = 16'h1234;
      tick(); start = 1'b0; br_req = 1'b0;
      chk("both_req", 16'(mem_rd_req), 16'h0);
      chk("both_bt", 16'(br_taken), 16'h1);
      chk("both_pcn", pc_next, 16'h1234);
      tick();
      chk("both_req2", 16'(mem_rd_req), 16'h0);
      chk("both_idle", 16'(busy), 16'h0);

      // reset mid-fetch, then a stray ack
      pc = 16'h0040; start = 1'b1;
      tick(); start = 1'b0;
      chk("rf_req", 16'(mem_rd_req), 16'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("rf_req_drop", 16'(mem_rd_req), 16'h0);
      chk("rf_busy", 16'(busy), 16'h1);
      chk("rf_addr", mem_addr, 16'h0);
      mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      tick(); reset_n = 1'b1;
      tick();
      chk("rf_pcen", 16'(pc_en), 16'h1);
      chk("rf_pcn", pc_next, 16'h0100);
      chk("rf_inen", 16'(instr_en), 16'h0);
      tick();
      chk("rf_inen2", 16'(instr_en), 16'h0);
      chk("rf_req2", 16'(mem_rd_req), 16'h0);
      chk("rf_idle", 16'(busy), 16'h0);
      mem_ack = 1'b0;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         start     = ($urandom_range(0, 3) == 0);
         br_req    = ($urandom_range(0, 5) == 0);
         br_cond   = 4'($urandom);
         br_rel    = 1'($urandom);
         br_target = 16'($urandom);
         psr       = 16'($urandom);
         pc        = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
         mem_ack   = ($urandom_range(0, 2) == 0);
         mem_rdata = 16'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            #2 reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
         end else begin
            tick();
         end
      end
      start = 1'b0; br_req = 1'b0; mem_ack = 1'b0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
